// File: rtl/trivium_pkg.sv
// trivium_pkg: shared Trivium constants, state type, tap positions and core phases.
package trivium_pkg;

    localparam int STATE_BITS    = 288;
    localparam int KEY_BITS      = 80;
    localparam int IV_BITS       = 80;
    localparam int WARMUP_ROUNDS = 1152;

    localparam int TAP_1A = 66;
    localparam int TAP_1B = 93;
    localparam int TAP_2A = 162;
    localparam int TAP_2B = 177;
    localparam int TAP_3A = 243;
    localparam int TAP_3B = 288;
    localparam int AND_1A = 91;
    localparam int AND_1B = 92;
    localparam int AND_2A = 175;
    localparam int AND_2B = 176;
    localparam int AND_3A = 286;
    localparam int AND_3B = 287;
    localparam int FB_1   = 171;
    localparam int FB_2   = 264;
    localparam int FB_3   = 69;

    typedef logic [1:STATE_BITS] trv_state_t;

    typedef enum logic [1:0] {LOAD, WARMUP, READY} trv_phase_e;

endpackage

// File: rtl/trivium_round_unroll.sv
// trivium_round_unroll: W Trivium rounds unrolled combinationally; z[0] is the earliest keystream bit.
module trivium_round_unroll
    import trivium_pkg::*;
#(
    parameter int W = 8
) (
    input  trv_state_t     state,
    output trv_state_t     nxt,
    output logic [0:W-1]   z
);

    trv_state_t s;
    logic t1, t2, t3;

    always_comb begin
        s  = state;
        z  = '0;
        t1 = 1'b0;
        t2 = 1'b0;
        t3 = 1'b0;
        for (int i = 0; i < W; i++) begin
            t1   = s[TAP_1A] ^ s[TAP_1B];
            t2   = s[TAP_2A] ^ s[TAP_2B];
            t3   = s[TAP_3A] ^ s[TAP_3B];
            z[i] = t1 ^ t2 ^ t3;
            t1   = t1 ^ (s[AND_1A] & s[AND_1B]) ^ s[FB_1];
            t2   = t2 ^ (s[AND_2A] & s[AND_2B]) ^ s[FB_2];
            t3   = t3 ^ (s[AND_3A] & s[AND_3B]) ^ s[FB_3];
            s    = {t3, s[1:TAP_1B-1], t1, s[TAP_1B+1:TAP_2B-1], t2, s[TAP_2B+1:TAP_3B-1]};
        end
        nxt = s;
    end

endmodule

// File: rtl/trivium_core_par.sv
// trivium_core_par: W-bit-per-clock Trivium core with serial key/IV load and a one-deep output register.
// Optional macro TRV_WORD_CNT_EN adds a saturating WORD_CNT of accepted data words.
module trivium_core_par #(
    parameter int W        = 8,
    parameter int KEY_BITS = 80,
    parameter int IV_BITS  = 80
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         KEY,
    input  logic         STB_KEY,
    input  logic [0:W-1] DATA,
    input  logic         STB_DATA,
    output logic         RDY_DATA,
    output logic [0:W-1] DATA_OUT,
    output logic         VALID_OUT,
    input  logic         READ,
    output logic         BUSY
`ifdef TRV_WORD_CNT_EN
    ,
    output logic [31:0]  WORD_CNT
`endif
);

    import trivium_pkg::*;

    localparam int LW   = $clog2(KEY_BITS + IV_BITS + 1);
    localparam int WCYC = WARMUP_ROUNDS / W;
    localparam int CW   = $clog2(WCYC + 1);
    localparam logic [LW-1:0] L_KEY  = LW'(KEY_BITS);
    localparam logic [LW-1:0] L_LAST = LW'(KEY_BITS + IV_BITS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(WCYC - 1);
    localparam logic [8:0]    POS_IV = 9'(TAP_1B + 1 - KEY_BITS);

    trv_phase_e      phase;
    trv_state_t      st, nxt;
    logic [0:W-1]    ks;
    logic [LW-1:0]   lcnt;
    logic [CW-1:0]   wcnt;
    logic [8:0]      pos;
    logic            accept;

    trivium_round_unroll #(.W(W)) u_round (
        .state (st),
        .nxt   (nxt),
        .z     (ks)
    );

    assign BUSY     = phase != READY;
    assign RDY_DATA = (phase == READY) && !STB_KEY && (!VALID_OUT || READ);
    assign accept   = STB_DATA && RDY_DATA;

    // key bits fill s1..s80, IV bits fill s94..s173
    always_comb pos = (lcnt < L_KEY) ? 9'(lcnt) + 9'd1 : 9'(lcnt) + POS_IV;

    always_ff @(posedge CLK) begin
        if (RST) begin
            phase     <= LOAD;
            lcnt      <= '0;
            wcnt      <= '0;
            st        <= '0;
            DATA_OUT  <= '0;
            VALID_OUT <= 1'b0;
        end else begin
            case (phase)
                LOAD: if (STB_KEY) begin
                    st[pos]           <= KEY;
                    st[AND_3A:TAP_3B] <= 3'b111;
                    lcnt              <= lcnt + LW'(1);
                    if (lcnt == L_LAST) begin
                        phase <= WARMUP;
                        wcnt  <= '0;
                    end
                end
                WARMUP: begin
                    st   <= nxt;
                    wcnt <= wcnt + CW'(1);
                    if (wcnt == C_LAST) phase <= READY;
                end
                default: if (STB_KEY) begin
                    st                <= '0;
                    st[1]             <= KEY;
                    st[AND_3A:TAP_3B] <= 3'b111;
                    lcnt              <= LW'(1);
                    VALID_OUT         <= 1'b0;
                    phase             <= LOAD;
                end else if (accept) begin
                    DATA_OUT  <= DATA ^ ks;
                    VALID_OUT <= 1'b1;
                    st        <= nxt;
                end else if (READ) begin
                    VALID_OUT <= 1'b0;
                end
            endcase
        end
    end

`ifdef TRV_WORD_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST || (phase == READY && STB_KEY)) WORD_CNT <= '0;
        else if (accept && !(&WORD_CNT)) WORD_CNT <= WORD_CNT + 32'd1;
    end
`endif

endmodule
